// File: rtl/nv_ram_fifo_pkg.sv
// Shared sizing and payload types for the 64x116 RAM-backed FIFO controller.
package nv_ram_fifo_pkg;

  localparam int unsigned FIFO_DEPTH = 64;
  localparam int unsigned FIFO_WIDTH = 116;
  localparam int unsigned FIFO_AW    = 6;
  localparam int unsigned FIFO_CW    = 7;

  typedef logic [FIFO_WIDTH-1:0] fifo_pd_t;
  typedef logic [FIFO_AW-1:0]    fifo_ptr_t;
  typedef logic [FIFO_CW-1:0]    fifo_cnt_t;

endpackage

// File: rtl/nv_ram_fifo_ctrl_64x116_if.sv
// Write/read handshake bundle of the FIFO controller; slave = FIFO side.
interface nv_ram_fifo_ctrl_64x116_if;
  import nv_ram_fifo_pkg::*;

  logic      wr_pvld;
  logic      wr_prdy;
  fifo_pd_t  wr_pd;
  logic      rd_pvld;
  logic      rd_prdy;
  fifo_pd_t  rd_pd;
  fifo_cnt_t wr_count;
  logic      wr_almost_full;

  modport master (
    output wr_pvld, wr_pd, rd_prdy,
    input  wr_prdy, rd_pvld, rd_pd, wr_count, wr_almost_full
  );

  modport slave (
    input  wr_pvld, wr_pd, rd_prdy,
    output wr_prdy, rd_pvld, rd_pd, wr_count, wr_almost_full
  );

endinterface

// File: rtl/nv_ram_fifo_oskid.sv
// Two-entry in-order output stage; the producer only pushes when it knows space exists.
module nv_ram_fifo_oskid #(
  parameter int unsigned WIDTH = 116
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_pd,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_pd,
  output logic [1:0]       cnt
);

  logic [1:0]       cnt_q, cnt_n;
  logic [WIDTH-1:0] head_q, tail_q, head_n, tail_n;
  logic             vld_q, pop;

  assign pop     = vld_q & out_rdy;
  assign out_vld = vld_q;
  assign out_pd  = head_q;
  assign cnt     = cnt_q;

  // Next head/tail/count from push and pop; head only moves on pop or fill-from-empty.
  always_comb begin
    head_n = head_q;
    tail_n = tail_q;
    cnt_n  = cnt_q;
    case ({in_vld, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_n = in_pd;
        else               tail_n = in_pd;
        cnt_n = cnt_q + 2'd1;
      end
      2'b01: begin
        head_n = tail_q;
        cnt_n  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          head_n = tail_q;
          tail_n = in_pd;
        end else begin
          head_n = in_pd;
        end
      end
      default: ;
    endcase
  end

  // Occupancy and valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
      vld_q <= 1'b0;
    end else begin
      cnt_q <= cnt_n;
      vld_q <= (cnt_n != 2'd0);
    end
  end

  // Payload storage, no reset needed.
  always_ff @(posedge clk) begin
    head_q <= head_n;
    tail_q <= tail_n;
  end

endmodule

// File: rtl/nv_ram_rws_64x116.sv
// 64x116 single-clock RAM: one write port, one read port with registered read.
module nv_ram_rws_64x116
  import nv_ram_fifo_pkg::*;
(
  input  logic        clk,
  input  logic        re,
  input  fifo_ptr_t   ra,
  output fifo_pd_t    dout,
  input  logic        we,
  input  fifo_ptr_t   wa,
  input  fifo_pd_t    di,
  input  logic [31:0] pwrbus_ram_pd
);

  fifo_pd_t mem [FIFO_DEPTH];

  // Power-control bus belongs to the hard macro; the behavioural array ignores it.
  logic unused_pwrbus;
  assign unused_pwrbus = ^pwrbus_ram_pd;

  // Array write and registered read; contents are never cleared.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= di;
    if (re) dout <= mem[ra];
  end

endmodule

// File: rtl/nv_ram_fifo_ctrl_64x116.sv
// RAM-backed 64x116 FIFO controller with a 2-entry output stage.
// Define NV_RAM_FIFO_BYPASS_EN to let writes into an empty FIFO skip the RAM.
module nv_ram_fifo_ctrl_64x116
  import nv_ram_fifo_pkg::*;
#(
  parameter int unsigned ALMOST_FULL_TH = 60
) (
  input  logic                            clk,
  input  logic                            rst,
  nv_ram_fifo_ctrl_64x116_if.slave        io,
  input  logic [31:0]                     pwrbus_ram_pd
);

  fifo_ptr_t  wr_ptr_q, rd_ptr_q;
  fifo_cnt_t  ram_cnt_q, occ_q, occ_n;
  logic       inflight_q, wr_prdy_q, afull_q;
  logic [1:0] out_cnt;
  fifo_pd_t   ram_dout, skid_pd, skid_out_pd;
  logic       push, pop, byp, ram_we, fetch, skid_vld, skid_out_vld;

  assign push = io.wr_pvld & wr_prdy_q;
  assign pop  = skid_out_vld & io.rd_prdy;

`ifdef NV_RAM_FIFO_BYPASS_EN
  assign byp = push & (ram_cnt_q == '0) & ~inflight_q & ((out_cnt != 2'd2) | pop);
`else
  assign byp = 1'b0;
`endif

  assign ram_we = push & ~byp;
  // Fetch only from entries already counted in the RAM; keep output stage + in-flight <= 2.
  assign fetch  = (ram_cnt_q != '0) &
                  ((3'(out_cnt) + 3'(inflight_q) - 3'(pop)) < 3'd2);

  assign skid_vld = inflight_q | byp;
  assign skid_pd  = inflight_q ? ram_dout : io.wr_pd;

  assign occ_n = occ_q + FIFO_CW'(push) - FIFO_CW'(pop);

  // Pointers, RAM occupancy, in-flight flag and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      occ_q      <= '0;
      wr_prdy_q  <= 1'b0;
      afull_q    <= 1'b0;
    end else begin
      if (ram_we) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (fetch)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      ram_cnt_q  <= ram_cnt_q + FIFO_CW'(ram_we) - FIFO_CW'(fetch);
      inflight_q <= fetch;
      occ_q      <= occ_n;
      // Held low through the cycle after reset because the reset branch clears it.
      wr_prdy_q  <= (occ_n < FIFO_CW'(FIFO_DEPTH));
      afull_q    <= (occ_n >= FIFO_CW'(ALMOST_FULL_TH));
    end
  end

  nv_ram_rws_64x116 u_ram (
    .clk           (clk),
    .re            (fetch),
    .ra            (rd_ptr_q),
    .dout          (ram_dout),
    .we            (ram_we),
    .wa            (wr_ptr_q),
    .di            (io.wr_pd),
    .pwrbus_ram_pd (pwrbus_ram_pd)
  );

  nv_ram_fifo_oskid #(.WIDTH(FIFO_WIDTH)) u_oskid (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (skid_vld),
    .in_pd   (skid_pd),
    .out_vld (skid_out_vld),
    .out_rdy (io.rd_prdy),
    .out_pd  (skid_out_pd),
    .cnt     (out_cnt)
  );

  assign io.wr_prdy        = wr_prdy_q;
  assign io.wr_count       = occ_q;
  assign io.wr_almost_full = afull_q;
  assign io.rd_pvld        = skid_out_vld;
  assign io.rd_pd          = skid_out_pd;

endmodule

// File: tb/tb_nv_ram_fifo_ctrl_64x116.sv
// Scoreboard bench for nv_ram_fifo_ctrl_64x116 (optionally built with NV_RAM_FIFO_BYPASS_EN).
module tb_nv_ram_fifo_ctrl_64x116;

  localparam int TH    = 60;
  localparam int DEPTH = 64;
`ifdef NV_RAM_FIFO_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 3;
`endif

  typedef struct {
    logic [115:0] d;
    int           w;
  } item_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nv_ram_fifo_ctrl_64x116_if io_if ();

  nv_ram_fifo_ctrl_64x116 #(.ALMOST_FULL_TH(TH)) dut (
    .clk           (clk),
    .rst           (rst),
    .io            (io_if),
    .pwrbus_ram_pd (32'h0)
  );

  item_t        exp_q[$];
  int           total = 0;
  int           bad   = 0;
  int           edge_n = 0;
  int           post_rst = 0;
  bit           armed = 1'b0;
  bit           stall_prev = 1'b0;
  logic [115:0] prev_pd;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endfunction

  function automatic logic [115:0] rand_pd();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[115:0];
  endfunction

  // Monitor: checks outputs against the model, pops the scoreboard on each read handshake.
  initial begin : monitor
    bit exp_vld;
    forever begin
      @(negedge clk);
      #1;
      if (armed) begin
        chk("wr_count", 128'(io_if.wr_count), 128'(exp_q.size()));
        chk("almost_full", 128'(io_if.wr_almost_full), 128'(exp_q.size() >= TH));
        chk("wr_prdy", 128'(io_if.wr_prdy), 128'((post_rst >= 1) && (exp_q.size() < DEPTH)));
        exp_vld = (exp_q.size() > 0) && (exp_q[0].w + 2 <= edge_n);
`ifdef NV_RAM_FIFO_BYPASS_EN
        if (exp_q.size() == 0 || exp_vld)
          chk("rd_pvld", 128'(io_if.rd_pvld), 128'(exp_vld));
`else
        chk("rd_pvld", 128'(io_if.rd_pvld), 128'(exp_vld));
`endif
        if (stall_prev) chk("rd_pd_hold", 128'(io_if.rd_pd), 128'(prev_pd));
        if (!rst && io_if.rd_pvld && io_if.rd_prdy && exp_q.size() > 0) begin
          chk("rd_pd", 128'(io_if.rd_pd), 128'(exp_q[0].d));
          void'(exp_q.pop_front());
        end
      end
      stall_prev = armed && !rst && io_if.rd_pvld && !io_if.rd_prdy;
      prev_pd    = io_if.rd_pd;
      if (rst) begin
        exp_q.delete();
        post_rst = 0;
        armed    = 1'b1;
      end else begin
        post_rst++;
      end
      edge_n++;
    end
  end

  // One cycle of stimulus; accepted writes are pushed into the scoreboard.
  task automatic step(input logic r, input logic pv, input logic [115:0] pd, input logic pr);
    item_t it;
    @(negedge clk);
    rst           = r;
    io_if.wr_pvld = pv;
    io_if.wr_pd   = pd;
    io_if.rd_prdy = pr;
    #3;
    if (!r && pv && io_if.wr_prdy) begin
      it.d = pd;
      it.w = edge_n;
      exp_q.push_back(it);
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("rst_wr_prdy_low", 128'(io_if.wr_prdy), 128'(0));
    chk("rst_rd_pvld", 128'(io_if.rd_pvld), 128'(0));
    step(1'b0, 1'b0, '0, 1'b0);
    chk("rst_wr_prdy_high", 128'(io_if.wr_prdy), 128'(1));
  endtask

  task automatic push_wait(input logic [115:0] d, input logic pr);
    int n = 0;
    do begin
      step(1'b0, 1'b1, d, pr);
      n++;
    end while (!io_if.wr_prdy && n < 200);
    if (n >= 200) fail_now("push_wait");
  endtask

  task automatic drain();
    int n = 0;
    while ((io_if.wr_count != 0 || io_if.rd_pvld) && n < 300) begin
      step(1'b0, 1'b0, '0, 1'b1);
      n++;
    end
    if (n >= 300) fail_now("drain");
    repeat (3) step(1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : driver
    int lat, wi, cyc, pc, first, last, wdone;
    rst           = 1'b1;
    io_if.wr_pvld = 1'b0;
    io_if.wr_pd   = '0;
    io_if.rd_prdy = 1'b0;
    do_reset();

    // Single write after reset: latency, data, count.
    step(1'b0, 1'b1, 116'h0ABC, 1'b1);
    chk("abc_accept", 128'(io_if.wr_prdy), 128'(1));
    lat = 0;
    do begin
      step(1'b0, 1'b0, '0, 1'b1);
      lat++;
    end while (!io_if.rd_pvld && lat < 20);
    chk("abc_latency", 128'(lat), 128'(LAT));
    chk("abc_pd", 128'(io_if.rd_pd), 128'(116'h0ABC));
    chk("abc_count1", 128'(io_if.wr_count), 128'(1));
    step(1'b0, 1'b0, '0, 1'b1);
    chk("abc_count0", 128'(io_if.wr_count), 128'(0));

    // Fill to 64 with the consumer stalled; 65th write is held.
    for (int i = 0; i < DEPTH; i++) push_wait(116'(i + 1), 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("full_count", 128'(io_if.wr_count), 128'(64));
    chk("full_prdy", 128'(io_if.wr_prdy), 128'(0));
    chk("full_afull", 128'(io_if.wr_almost_full), 128'(1));
    repeat (3) begin
      step(1'b0, 1'b1, 116'hDEAD, 1'b0);
      chk("held_prdy", 128'(io_if.wr_prdy), 128'(0));
    end

    // Pop once while full: slot reappears the following cycle.
    step(1'b0, 1'b0, '0, 1'b1);
    chk("pop_same_cycle_prdy", 128'(io_if.wr_prdy), 128'(0));
    step(1'b0, 1'b1, 116'h777, 1'b0);
    chk("pop_next_cycle_prdy", 128'(io_if.wr_prdy), 128'(1));
    step(1'b0, 1'b0, '0, 1'b0);
    chk("refill_count", 128'(io_if.wr_count), 128'(64));
    chk("refill_prdy", 128'(io_if.wr_prdy), 128'(0));
    drain();

    // Stream 200 incrementing items: one write and one pop per cycle once primed.
    wi = 0; cyc = 0; pc = 0; first = -1; last = -1; wdone = -1;
    while ((wi < 200 || pc < 200) && cyc < 500) begin
      step(1'b0, 1'(wi < 200), 116'(1000 + wi), 1'b1);
      if (wi < 200 && io_if.wr_prdy) begin
        wi++;
        if (wi == 200) wdone = cyc + 1;
      end
      if (io_if.rd_pvld) begin
        pc++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      cyc++;
    end
    chk("stream_items", 128'(pc), 128'(200));
    chk("stream_wr_rate", 128'(wdone), 128'(200));
    chk("stream_no_bubble", 128'(last - first + 1), 128'(200));
    drain();

    // Reset mid-operation with 10 entries, one fetch in flight.
    for (int i = 0; i < 11; i++) push_wait(116'(500 + i), 1'b0);
    repeat (3) step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0);
    chk("pre_rst_count", 128'(io_if.wr_count), 128'(10));
    step(1'b0, 1'b0, '0, 1'b0);
    chk("post_rst_pvld", 128'(io_if.rd_pvld), 128'(0));
    chk("post_rst_count", 128'(io_if.wr_count), 128'(0));
    chk("post_rst_prdy0", 128'(io_if.wr_prdy), 128'(0));
    step(1'b0, 1'b0, '0, 1'b1);
    chk("post_rst_prdy1", 128'(io_if.wr_prdy), 128'(1));
    repeat (4) step(1'b0, 1'b0, '0, 1'b1);

    // Random traffic with ~30% consumer backpressure.
    for (int i = 0; i < 800; i++)
      step(1'b0, 1'($urandom_range(0, 9) < 6), rand_pd(), 1'($urandom_range(0, 9) < 7));
    // Heavy writer, bursty reader to visit almost-full and full.
    for (int i = 0; i < 300; i++)
      step(1'b0, 1'b1, rand_pd(), 1'($urandom_range(0, 9) < 3));
    drain();
    chk("end_empty", 128'(io_if.wr_count), 128'(exp_q.size()));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nv_ram_fifo_ctrl_64x116.md
NV_RAM_FIFO_CTRL_64X116 -- requirements
Module: nv_ram_fifo_ctrl_64x116

Interface
REQ-001 SHALL have parameter ALMOST_FULL_TH, default 60: occupancy at or above which wr_almost_full asserts.
REQ-002 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port wr_pvld  input  1  write data valid.
REQ-005 SHALL have port wr_prdy  output  1  write accept; transfer on wr_pvld&wr_prdy.
REQ-006 SHALL have port wr_pd  input  116  write payload.
REQ-007 SHALL have port rd_pvld  output  1  read data valid.
REQ-008 SHALL have port rd_prdy  input  1  consumer ready; pop on rd_pvld&rd_prdy.
REQ-009 SHALL have port rd_pd  output  116  read payload, stable while rd_pvld&!rd_prdy.
REQ-010 SHALL have port wr_count  output  7  total occupancy 0..64.
REQ-011 SHALL have port wr_almost_full  output  1  wr_count >= ALMOST_FULL_TH.
REQ-012 SHALL have port pwrbus_ram_pd  input  32  passed unchanged to RAM instance.

Function
REQ-013 SHALL store entries in one 64x116 RAM with registered read address; RAM read data is valid the cycle after re.
REQ-014 SHALL track: wr_ptr[5:0], rd_ptr[5:0], ram_cnt 0..64, inflight 0..1, out_cnt 0..2 (2-entry output stage).
REQ-015 SHALL define wr_count = ram_cnt + inflight + out_cnt; wr_prdy = !rst_d & (wr_count < 64).
REQ-016 SHALL on accepted write: RAM[wr_ptr] <= wr_pd, wr_ptr+1 mod 64 (wrap 63->0), ram_cnt+1.
REQ-017 SHALL issue re (ra=rd_ptr) when ram_cnt>0 and (out_cnt + inflight - pop) < 2; then rd_ptr+1 mod 64, ram_cnt-1, inflight=1.
REQ-018 SHALL load RAM dout into output stage the cycle after re; output stage is in-order FIFO, rd_pd = head.
REQ-019 SHALL assert rd_pvld iff out_cnt>0.
REQ-020 SHALL sustain one write and one pop per cycle indefinitely once primed (no bubbles).
REQ-021 SHALL on simultaneous write and fetch with ram_cnt==0 not fetch; fetch eligibility uses registered ram_cnt only.
REQ-022 SHALL, without bypass, give write-to-rd_pvld latency 3 cycles on an empty FIFO.
REQ-023 SHALL when full (wr_count==64) deassert wr_prdy; simultaneous pop frees a slot the following cycle, not same cycle.
REQ-024 SHALL ignore rd_prdy when rd_pvld=0 and wr_pd when wr_prdy=0.

Reset
REQ-025 SHALL on rst: pointers, ram_cnt, inflight, out_cnt = 0; rd_pvld=0; wr_count=0; wr_almost_full=0; wr_prdy=0.
REQ-026 SHALL deassert wr_prdy for the reset cycle and one cycle after (rst_d), then follow REQ-015.
REQ-027 SHALL on reset mid-operation discard all contents, including in-flight fetch; RAM array not cleared.

Configuration
REQ-028 SHALL support macro NV_RAM_FIFO_BYPASS_EN.
REQ-029 SHALL with NV_RAM_FIFO_BYPASS_EN: accepted write with ram_cnt==0, inflight==0, out_cnt-pop<2 goes directly to output stage; RAM and wr_ptr untouched; latency 1.
REQ-030 SHALL without NV_RAM_FIFO_BYPASS_EN: all data passes through RAM; latency per REQ-022; ordering identical in both builds.

Structure
REQ-031 SHALL place FIFO_DEPTH=64, FIFO_WIDTH=116, FIFO_AW=6, FIFO_CW=7 in shared package nv_ram_fifo_pkg.
REQ-032 SHALL instantiate RAM as nv_ram_rws_64x116.
REQ-033 SHALL implement output stage as sub-module nv_ram_fifo_oskid (2-entry, valid/ready, width parameterised).

Verification
REQ-034 SHALL cover: single write 0xABC after reset, rd_prdy=1 -> rd_pvld rises cycle 3 (cycle 1 with bypass), rd_pd=0xABC, wr_count 1->0.
REQ-035 SHALL cover: 64 writes, rd_prdy=0 -> wr_count=64, wr_prdy=0, wr_almost_full from 60th write; 65th held.
REQ-036 SHALL cover: continuous write+read 200 items, incrementing data -> in-order, 1/cycle after priming, pointers wrap 63->0 three times.
REQ-037 SHALL cover: full, pop once -> wr_prdy=1 next cycle, one write accepted, wr_count back to 64.
REQ-038 SHALL cover: rst asserted with 10 entries and inflight=1 -> next cycle rd_pvld=0, wr_count=0; wr_prdy=1 two cycles after rst falls.
REQ-039 SHALL cover: random rd_prdy backpressure 30% -> rd_pd stable while stalled, no loss/duplication vs scoreboard.
